skid_pipe_reg: RTL
==================

# skid_pipe_reg

Parametrised pipeline register with a two-entry skid buffer and a valid/ready handshake on both sides. It is the successor to the plain clock-enabled 32-bit register used between CPU pipeline stages. Width and reset value are configurable, and it adds back-pressure, a full-throughput skid slot, and synchronous flush. It sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and replaces CE-driven stalling with handshake-driven stalling.

## Interface
Parameters:
- WIDTH, default 32: payload width in bits (≥1).
- RESET_VAL, default 0: value loaded into both data registers on reset.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous discard of all held entries.
- in_valid  in  1  upstream has data on in_data.
- in_ready  out  1  block can accept; equals (state != FULL) && !flush.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  out_data holds a valid entry; equals (state != EMPTY) && !flush.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH  the main register, driven directly (no mux).
- xfer_cnt  out  32  output transfer count; only present with SKID_PIPE_REG_STATS_EN.
- stall_cnt  out  32  back-pressure cycle count; only present with SKID_PIPE_REG_STATS_EN.

## Operation
- Storage: main register (drives out_data) and skid register, each WIDTH bits, plus a 2-bit state.
- Handshake events:
  - Input accept (acc_in) = in_valid && in_ready.
  - Output transfer (acc_out) = out_valid && out_ready.
- State EMPTY:
  - acc_in → main ← in_data, go to HALF.
  - Otherwise stay.
- State HALF:
  - acc_in && acc_out → main ← in_data, stay HALF.
  - acc_in only → skid ← in_data, go to FULL.
  - acc_out only → go to EMPTY.
  - Neither → stay.
- State FULL (in_ready = 0):
  - acc_out → main ← skid, go to HALF.
  - Otherwise stay.
- Flush: highest priority after reset.
  - State ← EMPTY.
  - Both handshakes are masked in the flush cycle, so no accept or transfer occurs.
  - Data registers hold their contents.
- Ordering: strict FIFO. The skid entry always follows the main entry.
- Data is never modified, dropped, or duplicated except by flush.
- in_valid is don't-care while in_ready = 0. The block does not require upstream to hold data stable.

## Timing
- Reset values:
  - State EMPTY.
  - main and skid = RESET_VAL, so out_data = RESET_VAL.
  - out_valid = 0, in_ready = 1.
  - xfer_cnt and stall_cnt = 0.
- Latency: data accepted at edge N is on out_data, with out_valid = 1, immediately after edge N (one cycle).
- Throughput: 1 transfer per cycle sustained while out_ready = 1.
- One cycle of out_ready = 0 with continuous input fills the skid slot. in_ready drops the following cycle with no data loss.
- No combinational path from in_valid or in_data to any output, or from out_ready to in_ready. Only flush is combinational to in_ready and out_valid.
- Reset asserted mid-transfer: state clears immediately (asynchronous) and the held entries are lost.
- Reset deassertion is synchronous to clk externally.

## Configuration
- SKID_PIPE_REG_STATS_EN defined:
  - xfer_cnt increments on every acc_out.
  - stall_cnt increments on every cycle with out_valid && !out_ready.
  - Both wrap 0xFFFFFFFF → 0.
  - Both are cleared only by rst; flush does not clear them.
- Not defined: counters and both ports are absent, and no counter logic is synthesised.

## Test plan
- Reset check: rst pulse → out_valid = 0, in_ready = 1, out_data = RESET_VAL (0x00000000); counters = 0.
- Streaming: WIDTH = 32, in_valid = 1 with data 1, 2, 3, … for 10 cycles, out_ready = 1 → out_data 1..10 one cycle after each accept; in_ready stays 1; xfer_cnt = 10.
- Skid fill and drain:
  - Stimulus: stream A, B, C with out_ready = 0 from the cycle after A is accepted.
  - Expected: A in main, B in skid, in_ready = 0, C held off.
  - Stimulus: raise out_ready.
  - Expected: outputs A, B, C in order; stall_cnt equals the number of stalled cycles.
- Flush while FULL: flush = 1 together with in_valid = 1 → in_ready = 0 and out_valid = 0 in that cycle; next cycle state EMPTY, no output until the next accept; xfer_cnt unchanged.
- Async reset mid-stream: assert rst between edges while FULL → out_valid = 0 and out_data = RESET_VAL before the next edge; resumes correctly after release.
- Counter wrap (STATS build): force xfer_cnt to 0xFFFFFFFF, then one transfer → xfer_cnt = 0.

Source files
------------

// File: rtl/skid_pipe_reg.sv
// skid_pipe_reg: pipeline register with a two-entry skid buffer and a
// valid/ready handshake on both sides.
//
// Handshake: a beat moves across a port on a rising edge where both valid and
// ready are high on that port. A source may not retract a beat once it has
// offered it, except that upstream in_valid is don't-care while in_ready is 0.
// in_ready and out_valid depend only on registered state and on flush, so
// neither side sees a combinational path from the other side's signals.
//
// Optional feature: define SKID_PIPE_REG_STATS_EN to add the xfer_cnt and
// stall_cnt statistics counters and their ports.
//
// state_dbg exposes the occupancy FSM (0 = EMPTY, 1 = HALF, 2 = FULL).
module skid_pipe_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
`ifdef SKID_PIPE_REG_STATS_EN
  output logic [31:0]      xfer_cnt,
  output logic [31:0]      stall_cnt,
`endif
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             acc_in;
  logic             acc_out;
  logic             load_main;
  logic             main_from_skid;
  logic             load_skid;

  // Flush masks both handshakes in the cycle it is asserted.
  assign in_ready  = (state != FULL) && !flush;
  assign out_valid = (state != EMPTY) && !flush;
  assign acc_in    = in_valid && in_ready;
  assign acc_out   = out_valid && out_ready;
  assign out_data  = main_q;
  assign state_dbg = state;

  // Occupancy state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_n;
  end

  // Next-state and data-register load decisions.
  always_comb begin
    state_n        = state;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_n = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (acc_in) begin
            load_main = 1'b1;
            state_n   = HALF;
          end
        end
        HALF: begin
          if (acc_in && acc_out) begin
            load_main = 1'b1;
          end else if (acc_in) begin
            load_skid = 1'b1;
            state_n   = FULL;
          end else if (acc_out) begin
            state_n = EMPTY;
          end
        end
        FULL: begin
          if (acc_out) begin
            load_main      = 1'b1;
            main_from_skid = 1'b1;
            state_n        = HALF;
          end
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  // Data registers; the skid entry is always the younger of the two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= RESET_VAL;
      skid_q <= RESET_VAL;
    end else begin
      if (load_main) main_q <= main_from_skid ? skid_q : in_data;
      if (load_skid) skid_q <= in_data;
    end
  end

`ifdef SKID_PIPE_REG_STATS_EN
  // Statistics counters; they wrap naturally and survive flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (acc_out)                 xfer_cnt  <= xfer_cnt + 32'd1;
      if (out_valid && !out_ready) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
